// File: rtl/regf_seq.sv
// Four-state instruction sequencer acting as initiator of an 8x8 register file:
// fetch operands (READ), compute (EXEC), write back (WRITE), one instruction per 4 cycles.
module regf_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  AA,
    output logic [2:0]  BA,
    input  logic [7:0]  PoA,
    input  logic [7:0]  PoB,
    output logic [2:0]  DA,
    output logic [7:0]  BuD,
    output logic        RW,
    output logic        done,
    output logic [7:0]  result,
    output logic [2:0]  flags,
    output logic        illegal
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_MOV  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_NOT  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_LDI  = 4'hA,
        OP_INC  = 4'hB,
        OP_DEC  = 4'hC,
        OP_ILLD = 4'hD,
        OP_ILLE = 4'hE,
        OP_ILLF = 4'hF
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [2:0]  dst_q, dst_d;
    logic [5:0]  imm_q, imm_d;
    logic [2:0]  aa_q, aa_d;
    logic [2:0]  ba_q, ba_d;
    logic [2:0]  da_q, da_d;
    logic [7:0]  opa_q, opa_d;
    logic [7:0]  opb_q, opb_d;
    logic [7:0]  result_q, result_d;
    logic [2:0]  flags_q, flags_d;
    logic        ready_q, ready_d;
    logic        rw_q, rw_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;

    logic [8:0]  sum9;
    logic [7:0]  alu_res;
    logic        alu_c;
    logic        alu_wr;
    logic        alu_ill;

    always_comb begin
        sum9    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        alu_ill = 1'b0;
        case (op_q)
            OP_NOP: alu_wr = 1'b0;
            OP_MOV: alu_res = opa_q;
            OP_ADD: begin
                sum9    = {1'b0, opa_q} + {1'b0, opb_q};
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
            end
            // Bit 8 of the 9-bit difference is the borrow (A < B).
            OP_SUB: begin
                sum9    = {1'b0, opa_q} - {1'b0, opb_q};
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
            end
            OP_AND: alu_res = opa_q & opb_q;
            OP_OR:  alu_res = opa_q | opb_q;
            OP_XOR: alu_res = opa_q ^ opb_q;
            OP_NOT: alu_res = ~opa_q;
            OP_SHL: begin
                alu_res = {opa_q[6:0], 1'b0};
                alu_c   = opa_q[7];
            end
            OP_SHR: begin
                alu_res = {1'b0, opa_q[7:1]};
                alu_c   = opa_q[0];
            end
            OP_LDI: alu_res = {2'b00, imm_q};
            OP_INC: begin
                sum9    = {1'b0, opa_q} + 9'd1;
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
            end
            OP_DEC: begin
                sum9    = {1'b0, opa_q} - 9'd1;
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
            end
            default: begin
                alu_wr  = 1'b0;
                alu_ill = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        imm_d     = imm_q;
        aa_d      = aa_q;
        ba_d      = ba_q;
        da_d      = da_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        result_d  = result_q;
        flags_d   = flags_q;
        ready_d   = ready_q;
        rw_d      = rw_q;
        done_d    = done_q;
        illegal_d = illegal_q;
        case (state_q)
            // ready is registered one cycle late so it stays low in the first cycle after reset.
            ST_IDLE: begin
                ready_d = 1'b1;
                if (instr_valid && ready_q) begin
                    state_d = ST_READ;
                    ready_d = 1'b0;
                    op_d    = op_t'(instr[15:12]);
                    dst_d   = instr[11:9];
                    aa_d    = instr[8:6];
                    ba_d    = instr[5:3];
                    imm_d   = instr[5:0];
                end
            end
            ST_READ: begin
                opa_d   = PoA;
                opb_d   = PoB;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (alu_wr) begin
                    result_d = alu_res;
                    flags_d  = {alu_res[7], alu_c, alu_res == 8'h00};
                end
                da_d      = dst_q;
                rw_d      = alu_wr;
                done_d    = 1'b1;
                illegal_d = alu_ill;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                rw_d      = 1'b0;
                done_d    = 1'b0;
                illegal_d = 1'b0;
                ready_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            dst_q     <= '0;
            imm_q     <= '0;
            aa_q      <= '0;
            ba_q      <= '0;
            da_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            ready_q   <= 1'b0;
            rw_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            imm_q     <= imm_d;
            aa_q      <= aa_d;
            ba_q      <= ba_d;
            da_q      <= da_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            ready_q   <= ready_d;
            rw_q      <= rw_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are masked by rst so a reset during WRITE cannot land a write or retire.
    assign RW          = rw_q & ~rst;
    assign done        = done_q & ~rst;
    assign illegal     = illegal_q & ~rst;
    assign instr_ready = ready_q;
    assign AA          = aa_q;
    assign BA          = ba_q;
    assign DA          = da_q;
    assign BuD         = result_q;
    assign result      = result_q;
    assign flags       = flags_q;

endmodule

// File: tb/tb_regf_seq.sv
// Bench for regf_seq: behavioural register-file environment, per-instruction reference model,
// directed scenarios followed by randomized instruction streams with random resets.
module tb_regf_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  AA, BA, DA;
    logic [7:0]  PoA, PoB, BuD, result;
    logic        RW, done, illegal;
    logic [2:0]  flags;

    always #5 clk = ~clk;

    regf_seq dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .AA          (AA),
        .BA          (BA),
        .PoA         (PoA),
        .PoB         (PoB),
        .DA          (DA),
        .BuD         (BuD),
        .RW          (RW),
        .done        (done),
        .result      (result),
        .flags       (flags),
        .illegal     (illegal)
    );

    // Register file seen by the sequencer; r0 discards writes.
    logic [7:0] rf [8] = '{default: 8'h00};
    assign PoA = rf[AA];
    assign PoB = rf[BA];
    always @(posedge clk) if (RW && DA != 3'd0) rf[DA] <= BuD;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       wr;
        logic       ill;
        logic       c;
        logic [7:0] res;
    } exp_t;

    function automatic exp_t model_exec(input logic [15:0] ins, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ia = int'(a);
        int ib = int'(b);
        int r  = 0;
        e.wr = 1'b1; e.ill = 1'b0; e.c = 1'b0;
        case (ins[15:12])
            4'h0: e.wr = 1'b0;
            4'h1: r = ia;
            4'h2: begin r = ia + ib; e.c = (r > 255); end
            4'h3: begin r = ia - ib; e.c = (ia < ib); end
            4'h4: r = ia & ib;
            4'h5: r = ia | ib;
            4'h6: r = ia ^ ib;
            4'h7: r = 255 - ia;
            4'h8: begin r = ia * 2; e.c = a[7]; end
            4'h9: begin r = ia / 2; e.c = a[0]; end
            4'hA: r = int'(ins[5:0]);
            4'hB: begin r = ia + 1; e.c = (r > 255); end
            4'hC: begin r = ia - 1; e.c = (ia == 0); end
            default: begin e.wr = 1'b0; e.ill = 1'b1; end
        endcase
        e.res = 8'(r & 255);
        return e;
    endfunction

    logic [7:0]  mregs [8] = '{default: 8'h00};
    logic [7:0]  mresult = 8'h00;
    logic [2:0]  mflags = 3'b000;
    logic [2:0]  exp_aa = '0, exp_ba = '0, exp_da = '0;
    logic [15:0] pend[$];
    int          cyc = 0, hs_cyc = 0;
    bit          hs_seen = 0, rst_edge = 0;
    int          retire_cnt = 0;
    logic [7:0]  last_bud;
    logic [2:0]  last_da, last_flags;
    logic        last_rw, last_ill;
    logic [2:0]  da_log[$];
    int          hs_log[$];

    // Monitor: bookkeeping on the rising edge, checks on the falling edge.
    initial begin
        logic [15:0] ins;
        exp_t        e;
        logic        exp_ready;
        forever begin
            @(posedge clk);
            cyc++;
            rst_edge = rst;
            if (rst) begin
                pend.delete();
                hs_seen = 0;
                mresult = 8'h00; mflags = 3'b000;
                exp_aa = '0; exp_ba = '0; exp_da = '0;
            end else if (instr_valid && instr_ready) begin
                hs_seen = 1;
                hs_cyc  = cyc;
                pend.push_back(instr);
                exp_aa = instr[8:6];
                exp_ba = instr[5:3];
                hs_log.push_back(cyc);
            end
            @(negedge clk);
            if (rst_edge) begin
                chk("rst_ready", 32'(instr_ready), 32'd0);
                chk("rst_addr", 32'({AA, BA, DA}), 32'd0);
                chk("rst_bud", 32'(BuD), 32'd0);
                chk("rst_strobes", 32'({RW, done, illegal}), 32'd0);
                chk("rst_result", 32'(result), 32'd0);
                chk("rst_flags", 32'(flags), 32'd0);
            end else begin
                exp_ready = !(hs_seen && cyc <= hs_cyc + 2);
                chk("ready", 32'(instr_ready), 32'(exp_ready));
                chk("aa", 32'(AA), 32'(exp_aa));
                chk("ba", 32'(BA), 32'(exp_ba));
                if (hs_seen && cyc == hs_cyc + 2 && pend.size() > 0) begin
                    ins = pend.pop_front();
                    e = model_exec(ins, mregs[ins[8:6]], mregs[ins[5:3]]);
                    exp_da = ins[11:9];
                    if (e.wr) begin
                        mresult = e.res;
                        mflags  = {e.res[7], e.c, e.res == 8'h00};
                    end
                    if (rst) begin
                        chk("abort_strobes", 32'({RW, done, illegal}), 32'd0);
                    end else begin
                        chk("done", 32'(done), 32'd1);
                        chk("rw", 32'(RW), 32'(e.wr));
                        chk("illegal", 32'(illegal), 32'(e.ill));
                        if (e.wr) chk("bud", 32'(BuD), 32'(e.res));
                        if (e.wr && ins[11:9] != 3'd0) mregs[ins[11:9]] = e.res;
                        last_bud = BuD; last_da = DA; last_flags = flags;
                        last_rw = RW; last_ill = illegal;
                        da_log.push_back(DA);
                        retire_cnt++;
                    end
                end else begin
                    chk("idle_strobes", 32'({RW, done, illegal}), 32'd0);
                end
                chk("da", 32'(DA), 32'(exp_da));
                chk("result", 32'(result), 32'(mresult));
                chk("flags", 32'(flags), 32'(mflags));
            end
        end
    end

    function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] d, input logic [2:0] a,
                                       input logic [2:0] b);
        return {op, d, a, b, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] d, input logic [5:0] imm);
        return {4'hA, d, 3'b000, imm};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents an instruction with valid high and returns 1 time unit after its handshake edge.
    task automatic issue(input logic [15:0] ins);
        bit got = 0;
        instr       = ins;
        instr_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            if (instr_ready && !rst) begin
                got = 1;
                break;
            end
        end
        #1;
        chk("hs_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_retire(input int target);
        for (int n = 0; n < 40 && retire_cnt < target; n++) begin
            @(posedge clk);
            #2;
        end
        chk("retire_timeout", 32'(retire_cnt >= target), 32'd1);
    endtask

    task automatic exec(input logic [15:0] ins);
        int c = retire_cnt;
        issue(ins);
        instr_valid = 1'b0;
        wait_retire(c + 1);
    endtask

    task automatic rst_pulse(input int k);
        instr_valid = 1'b0;
        idle(k);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int rcnt, n0, d0;
        logic [15:0] rnd;
        int choice;
        rst = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        exec(ldi(3'd1, 6'h3F));
        exec(ldi(3'd2, 6'h01));
        exec(rr(4'h2, 3'd3, 3'd1, 3'd2));
        chk("add_da", 32'(last_da), 32'd3);
        chk("add_bud", 32'(last_bud), 32'h40);
        chk("add_flags", 32'(last_flags), 32'b000);
        chk("add_rw", 32'(last_rw), 32'd1);

        exec(ldi(3'd1, 6'h05));
        exec(ldi(3'd2, 6'h06));
        exec(rr(4'h3, 3'd4, 3'd1, 3'd2));
        chk("sub_bud", 32'(last_bud), 32'hFF);
        chk("sub_flags", 32'(last_flags), 32'b110);
        exec(rr(4'hB, 3'd5, 3'd4, 3'd0));
        chk("inc_bud", 32'(last_bud), 32'h00);
        chk("inc_flags", 32'(last_flags), 32'b011);

        exec(ldi(3'd1, 6'h3F));
        exec(rr(4'h1, 3'd0, 3'd1, 3'd0));
        chk("mov0_rw", 32'(last_rw), 32'd1);
        chk("mov0_da", 32'(last_da), 32'd0);
        chk("mov0_result", 32'(result), 32'h3F);
        exec(rr(4'h1, 3'd6, 3'd0, 3'd0));
        chk("mov6_bud", 32'(last_bud), 32'h00);

        exec(rr(4'h2, 3'd3, 3'd0, 3'd0));
        chk("zero_flags", 32'(last_flags), 32'b001);
        exec({4'hE, 3'd5, 3'd1, 3'd2, 3'b000});
        chk("ill_pulse", 32'(last_ill), 32'd1);
        chk("ill_rw", 32'(last_rw), 32'd0);
        chk("ill_result", 32'(result), 32'h00);
        chk("ill_flags", 32'(flags), 32'b001);

        exec(ldi(3'd3, 6'h2A));
        exec(ldi(3'd1, 6'h05));
        exec(ldi(3'd2, 6'h06));
        rcnt = retire_cnt;
        issue(rr(4'h2, 3'd3, 3'd1, 3'd2));
        instr_valid = 1'b0;
        idle(1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        chk("rst_no_retire", 32'(retire_cnt), 32'(rcnt));
        exec(rr(4'h1, 3'd7, 3'd3, 3'd0));
        chk("r3_kept", 32'(last_bud), 32'h2A);

        n0 = hs_log.size();
        d0 = da_log.size();
        rcnt = retire_cnt;
        issue(ldi(3'd1, 6'h11));
        issue(ldi(3'd2, 6'h22));
        issue(ldi(3'd4, 6'h33));
        instr_valid = 1'b0;
        wait_retire(rcnt + 3);
        chk("b2b_count", 32'(da_log.size() - d0), 32'd3);
        if (da_log.size() - d0 == 3 && hs_log.size() - n0 == 3) begin
            chk("b2b_gap1", 32'(hs_log[n0 + 1] - hs_log[n0]), 32'd4);
            chk("b2b_gap2", 32'(hs_log[n0 + 2] - hs_log[n0 + 1]), 32'd4);
            chk("b2b_da0", 32'(da_log[d0]), 32'd1);
            chk("b2b_da1", 32'(da_log[d0 + 1]), 32'd2);
            chk("b2b_da2", 32'(da_log[d0 + 2]), 32'd4);
        end

        for (int i = 0; i < 300; i++) begin
            rnd = 16'($urandom());
            issue(rnd);
            choice = $urandom_range(0, 19);
            if (choice == 0) begin
                rst_pulse($urandom_range(0, 2));
            end else if (choice >= 8) begin
                instr_valid = 1'b0;
                idle($urandom_range(0, 3));
            end
        end
        instr_valid = 1'b0;
        idle(8);
        for (int i = 0; i < 8; i++) chk("rf_final", 32'(rf[i]), 32'(mregs[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the end of stimulus");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule

// File: doc/regf_seq.md
# regf_seq

Multicycle instruction sequencer that drives the 8-entry × 8-bit register file as its initiator. It accepts one 16-bit register-to-register instruction per handshake and issues the register-file read addresses. It captures the returned operands, computes the result with an internal 8-bit ALU, and issues the write-back. It sits between the instruction source (fetch/test harness) and the register file, and owns every register-file control signal.

## Interface
Parameters:
- none (datapath fixed at 8 bits, 8 registers, 16-bit instruction)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  16  instruction word: [15:12] opcode, [11:9] DA, [8:6] AA, [5:3] BA, [5:0] imm6
- instr_valid  in  1  instr is valid
- instr_ready  out  1  sequencer can accept; high only in IDLE
- AA  out  3  register-file read address A
- BA  out  3  register-file read address B
- PoA  in  8  register-file read data A (combinational from AA)
- PoB  in  8  register-file read data B (combinational from BA)
- DA  out  3  register-file write address
- BuD  out  8  register-file write data
- RW  out  1  register-file write enable
- done  out  1  one-cycle pulse when an instruction retires
- result  out  8  last computed result; held until the next EXEC
- flags  out  3  {N, C, Z} of last result; held
- illegal  out  1  one-cycle pulse with done when the opcode is undefined

## Operation
- Reset: every output is 0, including instr_ready. The state register is IDLE. instr_ready rises in the first cycle after rst deasserts.
- A handshake occurs when instr_valid & instr_ready are both high at a rising edge. The instruction is latched, and the sequencer moves IDLE→READ.
- READ: AA and BA are driven from the latched fields. PoA and PoB are captured into the operand registers at the end of the cycle. Next state is EXEC.
- EXEC: the ALU computes into result and flags. Next state is WRITE.
- WRITE: DA and BuD are driven, with BuD equal to result. RW is asserted for writing opcodes. done pulses. Next state is IDLE.
- Opcodes (A = PoA operand, B = PoB operand):
  - 0 NOP: no write.
  - 1 MOV: A.
  - 2 ADD: A+B, C = carry out.
  - 3 SUB: A−B, C = borrow (A<B).
  - 4 AND: A&B.
  - 5 OR: A|B.
  - 6 XOR: A^B.
  - 7 NOT: ~A.
  - 8 SHL: A<<1, C = A[7].
  - 9 SHR: logical A>>1, C = A[0].
  - A LDI: {2'b00, imm6}, no operands used.
  - B INC: A+1, C = carry.
  - C DEC: A−1, C = borrow (A==0).
  - D–F: illegal. No write, result and flags unchanged, illegal pulses with done.
- Flag rules: Z = (result==0) and N = result[7] for every writing opcode. C = 0 for logic ops, MOV and LDI. NOP and illegal opcodes leave flags unchanged.
- Arithmetic is modulo 256; overflow wraps silently.
- DA=0 with a writing opcode: RW is still asserted. The register file discards the write (r0 stays 0), while result and flags still reflect the computed value.
- DA equal to AA or BA is permitted. Operands are captured in READ, before the write in WRITE.
- AA, BA and DA are held at their last values outside the states that use them. RW is 0 in every state except WRITE.
- Reset mid-instruction, in any state: the instruction is aborted. The next cycle has RW=0, done=0 and state IDLE, and no write occurs.
- instr_valid while not ready: ignored. The source must hold instr stable until the handshake.

## Timing
- Handshake at edge T0. READ runs T0–T1, EXEC T1–T2, WRITE T2–T3.
- The register write lands at edge T3. done and RW are high during cycle T2–T3.
- instr_ready is high again during T3–T4. With instr_valid held, the next handshake is at T4. Throughput is 1 instruction per 4 cycles.
- result and flags update at edge T2.
- A dependent instruction reads the new register value: its READ starts after T4 > T3.

## Test plan
- After rst: LDI r1,#0x3F then LDI r2,#0x01, then ADD r3,r1,r2 → RW pulse with DA=3, BuD=0x40; flags N=0, C=0, Z=0; done pulses exactly once per instruction, 4 cycles apart.
- r1=0x05, r2=0x06, SUB r4,r1,r2 → BuD=0xFF, C=1, N=1, Z=0. Then INC r5,r4 → BuD=0x00, C=1, Z=1.
- MOV r0,r1 with r1=0x3F → RW=1, DA=0 in WRITE, result=0x3F. A following MOV r6,r0 writes 0x00.
- Opcode 0xE, preceded by ADD with Z=1 → done=1, illegal=1, RW=0 throughout; result and flags unchanged.
- rst asserted in EXEC of ADD r3,r1,r2 → no RW pulse, no done, all outputs 0 next cycle. r3 retains its old value (checked by a later MOV).
- instr_valid held high with 3 queued instructions → instr_ready low for exactly 3 of every 4 cycles. No instruction dropped or duplicated, checked by the write-back address sequence.
